crc_frame_checker: RTL and testbench
====================================

// Module: crc_frame_checker
// PURPOSE
// Receive-side companion of the parallel CRC generator: accepts a byte stream of frames, each payload followed by
// a CRC_WIDTH/8-byte CRC trailer, recomputes the CRC over the payload and compares it with the trailer.
// Sits between the link receive path and frame consumers; reports pass/fail per frame and keeps saturating counters.
// PARAMETERS
// DATA_BYTES  8   bytes per input beat (>=1)
// CRC_WIDTH   32  CRC width in bits; multiple of 8, >=8; CRC_BYTES = CRC_WIDTH/8
// PORTS
// clk            in   1                     clock
// rst            in   1                     synchronous reset, active-high
// in_valid       in   1                     beat valid
// in_ready       out  1                     beat accepted when in_valid & in_ready
// in_data        in   DATA_BYTES*8          beat; first byte = in_data[DATA_BYTES*8-1 -: 8]
// in_sop, in_eop in   1 each                first/last beat of frame (both high = 1-beat frame)
// in_nbytes      in   $clog2(DATA_BYTES+1)  valid bytes on EOP beat (high bytes); 0 or >DATA_BYTES = DATA_BYTES
// polynomial, crc_init, final_xor_val  in  CRC_WIDTH each    CRC config, sampled on SOP accept
// reflect_in, reflect_out  in  1 each       per-byte input reflect / full-result reflect, sampled on SOP accept
// result_valid   out  1                     frame result available
// result_ready   in   1                     result consumed when result_valid & result_ready
// result_ok      out  1                     computed CRC == received trailer, and not runt
// result_runt    out  1                     frame shorter than CRC_BYTES+1 bytes
// result_crc     out  CRC_WIDTH             computed CRC (after final XOR / reflect_out)
// result_rx_crc  out  CRC_WIDTH             received trailer; first trailer byte = bits [CRC_WIDTH-1 -: 8]
// frames_ok_cnt, frames_bad_cnt, frames_abort_cnt  out  16 each  saturating at 16'hFFFF
// BEHAVIOUR
// - Reset: state IDLE; in_ready=1, result_valid=0, result_ok=0, result_runt=0, result_crc=0, result_rx_crc=0,
//   all counters 0, config regs 0, crc_acc=0, byte window=0, byte count=0. Reset mid-frame discards it, no count.
// - States: IDLE, BODY, DONE. in_ready = (state != DONE).
// - IDLE: accepted beat without in_sop dropped silently. SOP accept: latch config, crc_acc<=crc_init, window cleared,
//   process beat; eop ? DONE : BODY.
// - BODY: accepted beat processed; eop -> DONE. Accepted in_sop restarts frame (same as IDLE SOP),
//   frames_abort_cnt++; no result for aborted frame.
// - Byte processing, in stream order per beat: each byte shifts into a CRC_BYTES-deep byte window; byte pushed out of
//   a full window feeds CRC: b' = reflect_in ? bitrev8(b) : b; acc ^= b'<<(CRC_WIDTH-8); 8x{ acc = msb ?
//   (acc<<1)^poly : acc<<1 }. All valid bytes of a beat handled in one cycle (combinational unroll).
// - Byte count saturates at CRC_BYTES+1 (only runt detection needed).
// - Entering DONE (cycle after EOP accept): result_valid=1; result_rx_crc = window (oldest byte in MSBs);
//   result_crc = reflect_out ? bitrev(acc^final_xor_val) : (acc^final_xor_val); result_runt = count<=CRC_BYTES;
//   result_ok = !runt & (result_crc==result_rx_crc); same edge increments frames_ok_cnt or frames_bad_cnt.
// - DONE: result outputs stable while result_valid & !result_ready; result_ready -> IDLE next cycle
//   (result_valid=0). One bubble cycle between frames minimum.
// - Latency: result_valid 1 cycle after EOP beat accepted. Throughput: DATA_BYTES bytes/cycle in BODY.
// - Counters saturate; never wrap.
// TESTING
// 1 CRC-32 (poly 04C11DB7, init FFFFFFFF, xor FFFFFFFF, refl in/out=1), DATA_BYTES=8: "12345678" | "9",CB,F4,39,26
//   nbytes=5 -> result_ok=1, result_crc=result_rx_crc=CBF43926, frames_ok_cnt=1.
// 2 Same frame, trailer CB,F4,39,27 -> result_ok=0, result_crc=CBF43926, result_rx_crc=CBF43927, frames_bad_cnt=1.
// 3 CRC-32/MPEG-2 (refl=0, xor 0): "123456789"+03,76,E6,E7 as one SOP/EOP... 2 beats -> result_ok=1, crc=0376E6E7.
// 4 Single beat sop=eop=1, nbytes=3 -> result_runt=1, result_ok=0, frames_bad_cnt++.
// 5 Hold result_ready=0 5 cycles -> in_ready=0, results unchanged; result_ready=1 -> IDLE, in_ready=1 next cycle.
// 6 SOP mid-frame -> frames_abort_cnt=1, new frame checked correctly; rst mid-frame -> all outputs at reset values.

Source files
------------

// File: rtl/crc_frame_checker.sv
`default_nettype none
// ============================================================================
// Module      : crc_frame_checker
// Description : Receive-side CRC checker. Accepts a byte stream of frames in
//               which each payload is followed by a CRC_WIDTH/8-byte trailer.
//               It recomputes the CRC over the payload, compares it with the
//               trailer, reports pass/fail/runt per frame and keeps three
//               saturating frame counters.
// Ports       : clk, rst               clock, synchronous active-high reset
//               in_*_i / in_ready_o    beat stream (valid/ready, sop/eop,
//                                      nbytes = valid high bytes on EOP beat)
//               polynomial_i, crc_init_i, final_xor_val_i, reflect_in_i,
//               reflect_out_i          CRC configuration, sampled on SOP
//               result_*               per-frame result (valid/ready)
//               frames_*_cnt_o         saturating 16-bit frame counters
// Revision    : 1.0 - initial release
// ============================================================================
module crc_frame_checker #(
    parameter int DATA_BYTES = 8,
    parameter int CRC_WIDTH  = 32
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               in_valid_i,
    output logic                               in_ready_o,
    input  logic [DATA_BYTES*8-1:0]            in_data_i,
    input  logic                               in_sop_i,
    input  logic                               in_eop_i,
    input  logic [$clog2(DATA_BYTES+1)-1:0]    in_nbytes_i,
    input  logic [CRC_WIDTH-1:0]               polynomial_i,
    input  logic [CRC_WIDTH-1:0]               crc_init_i,
    input  logic [CRC_WIDTH-1:0]               final_xor_val_i,
    input  logic                               reflect_in_i,
    input  logic                               reflect_out_i,
    output logic                               result_valid_o,
    input  logic                               result_ready_i,
    output logic                               result_ok_o,
    output logic                               result_runt_o,
    output logic [CRC_WIDTH-1:0]               result_crc_o,
    output logic [CRC_WIDTH-1:0]               result_rx_crc_o,
    output logic [15:0]                        frames_ok_cnt_o,
    output logic [15:0]                        frames_bad_cnt_o,
    output logic [15:0]                        frames_abort_cnt_o
);

    localparam int c_CRC_BYTES = CRC_WIDTH / 8;
    localparam int c_NB_W      = $clog2(DATA_BYTES + 1);
    localparam int c_CNT_W     = $clog2(c_CRC_BYTES + 2);

    localparam logic [c_NB_W-1:0]  c_NB_MAX   = c_NB_W'(DATA_BYTES);
    localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(c_CRC_BYTES);
    localparam logic [c_CNT_W-1:0] c_CNT_SAT  = c_CNT_W'(c_CRC_BYTES + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BODY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic logic [7:0] bitrev8(input logic [7:0] v);
        for (int k = 0; k < 8; k++) bitrev8[k] = v[7-k];
    endfunction

    function automatic logic [CRC_WIDTH-1:0] bitrev_crc(input logic [CRC_WIDTH-1:0] v);
        for (int k = 0; k < CRC_WIDTH; k++) bitrev_crc[k] = v[CRC_WIDTH-1-k];
    endfunction

    state_t                 state_q;
    logic [CRC_WIDTH-1:0]   poly_q, xor_q;
    logic                   rin_q, rout_q;
    logic [CRC_WIDTH-1:0]   acc_q, acc_d;
    logic [CRC_WIDTH-1:0]   win_q, win_d;
    logic [c_CNT_W-1:0]     cnt_q, cnt_d;
    logic                   result_valid_q, result_ok_q, result_runt_q;
    logic [CRC_WIDTH-1:0]   result_crc_q, result_rx_q;
    logic [15:0]            ok_cnt_q, bad_cnt_q, abort_cnt_q;

    logic                   w_accept, w_start, w_proc;
    logic [CRC_WIDTH-1:0]   w_poly, w_xor, w_fx, w_res_crc;
    logic                   w_rin, w_rout, w_runt, w_ok;
    int                     w_nvalid;
    logic [7:0]             w_byte, w_out;

    assign in_ready_o = (state_q != S_DONE);
    assign w_accept   = in_valid_i & in_ready_o;
    assign w_start    = w_accept & in_sop_i;
    // Non-SOP beats are only meaningful inside a frame; in IDLE they are dropped.
    assign w_proc     = w_accept & (in_sop_i | (state_q == S_BODY));

    // An SOP beat must already be processed with its own (not yet latched) config.
    assign w_poly = w_start ? polynomial_i    : poly_q;
    assign w_xor  = w_start ? final_xor_val_i : xor_q;
    assign w_rin  = w_start ? reflect_in_i    : rin_q;
    assign w_rout = w_start ? reflect_out_i   : rout_q;

    // The last CRC_BYTES bytes seen are held back in a window; only bytes that
    // fall out of a full window are payload and enter the CRC.
    always_comb begin
        acc_d    = w_start ? crc_init_i : acc_q;
        win_d    = w_start ? '0 : win_q;
        cnt_d    = w_start ? '0 : cnt_q;
        w_byte   = '0;
        w_out    = '0;
        w_nvalid = DATA_BYTES;
        if (in_eop_i && (in_nbytes_i != '0) && (in_nbytes_i <= c_NB_MAX))
            w_nvalid = int'(in_nbytes_i);
        for (int i = 0; i < DATA_BYTES; i++) begin
            if (w_proc && (i < w_nvalid)) begin
                w_byte = in_data_i[DATA_BYTES*8-1-8*i -: 8];
                if (cnt_d >= c_CNT_FULL) begin
                    w_out = win_d[CRC_WIDTH-1 -: 8];
                    if (w_rin) w_out = bitrev8(w_out);
                    acc_d = acc_d ^ (CRC_WIDTH'(w_out) << (CRC_WIDTH - 8));
                    for (int b = 0; b < 8; b++)
                        acc_d = acc_d[CRC_WIDTH-1] ? ((acc_d << 1) ^ w_poly) : (acc_d << 1);
                end
                win_d = (win_d << 8) | CRC_WIDTH'(w_byte);
                // Only "more than CRC_BYTES" matters, so the count stops there.
                if (cnt_d != c_CNT_SAT) cnt_d = cnt_d + 1'b1;
            end
        end
    end

    assign w_fx      = acc_d ^ w_xor;
    assign w_res_crc = w_rout ? bitrev_crc(w_fx) : w_fx;
    assign w_runt    = (cnt_d <= c_CNT_FULL);
    assign w_ok      = !w_runt && (w_res_crc == win_d);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            poly_q         <= '0;
            xor_q          <= '0;
            rin_q          <= 1'b0;
            rout_q         <= 1'b0;
            acc_q          <= '0;
            win_q          <= '0;
            cnt_q          <= '0;
            result_valid_q <= 1'b0;
            result_ok_q    <= 1'b0;
            result_runt_q  <= 1'b0;
            result_crc_q   <= '0;
            result_rx_q    <= '0;
            ok_cnt_q       <= '0;
            bad_cnt_q      <= '0;
            abort_cnt_q    <= '0;
        end else begin
            if (w_start) begin
                poly_q <= polynomial_i;
                xor_q  <= final_xor_val_i;
                rin_q  <= reflect_in_i;
                rout_q <= reflect_out_i;
            end
            if (w_proc) begin
                acc_q <= acc_d;
                win_q <= win_d;
                cnt_q <= cnt_d;
            end
            // SOP inside a frame abandons the frame in progress.
            if (w_start && (state_q == S_BODY) && (abort_cnt_q != 16'hFFFF))
                abort_cnt_q <= abort_cnt_q + 16'd1;

            if (w_proc && in_eop_i) begin
                state_q        <= S_DONE;
                result_valid_q <= 1'b1;
                result_ok_q    <= w_ok;
                result_runt_q  <= w_runt;
                result_crc_q   <= w_res_crc;
                result_rx_q    <= win_d;
                if (w_ok) begin
                    if (ok_cnt_q != 16'hFFFF) ok_cnt_q <= ok_cnt_q + 16'd1;
                end else begin
                    if (bad_cnt_q != 16'hFFFF) bad_cnt_q <= bad_cnt_q + 16'd1;
                end
            end else if (w_proc) begin
                state_q <= S_BODY;
            end else if ((state_q == S_DONE) && result_ready_i) begin
                state_q        <= S_IDLE;
                result_valid_q <= 1'b0;
            end
        end
    end

    assign result_valid_o     = result_valid_q;
    assign result_ok_o        = result_ok_q;
    assign result_runt_o      = result_runt_q;
    assign result_crc_o       = result_crc_q;
    assign result_rx_crc_o    = result_rx_q;
    assign frames_ok_cnt_o    = ok_cnt_q;
    assign frames_bad_cnt_o   = bad_cnt_q;
    assign frames_abort_cnt_o = abort_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_crc_frame_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_crc_frame_checker
// Description : Directed self-checking bench for crc_frame_checker
//               (DATA_BYTES=8, CRC_WIDTH=32) with an expected-result queue and
//               an independent bitwise CRC reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_crc_frame_checker;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic        ok;
        logic        runt;
        logic [31:0] crc;
        logic [31:0] rx;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_sop, in_eop;
    logic [63:0] in_data;
    logic [3:0]  in_nbytes;
    logic [31:0] poly, init, xorv;
    logic        rin, rout;
    logic        result_valid, result_ready, result_ok, result_runt;
    logic [31:0] result_crc, result_rx_crc;
    logic [15:0] ok_cnt, bad_cnt, abort_cnt;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   exp_ok = 0, exp_bad = 0, exp_abort = 0;

    always #5 clk = ~clk;

    crc_frame_checker #(.DATA_BYTES(8), .CRC_WIDTH(32)) dut (
        .clk               (clk),
        .rst               (rst),
        .in_valid_i        (in_valid),
        .in_ready_o        (in_ready),
        .in_data_i         (in_data),
        .in_sop_i          (in_sop),
        .in_eop_i          (in_eop),
        .in_nbytes_i       (in_nbytes),
        .polynomial_i      (poly),
        .crc_init_i        (init),
        .final_xor_val_i   (xorv),
        .reflect_in_i      (rin),
        .reflect_out_i     (rout),
        .result_valid_o    (result_valid),
        .result_ready_i    (result_ready),
        .result_ok_o       (result_ok),
        .result_runt_o     (result_runt),
        .result_crc_o      (result_crc),
        .result_rx_crc_o   (result_rx_crc),
        .frames_ok_cnt_o   (ok_cnt),
        .frames_bad_cnt_o  (bad_cnt),
        .frames_abort_cnt_o(abort_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rev32(input logic [31:0] v);
        for (int k = 0; k < 32; k++) rev32[k] = v[31-k];
    endfunction

    // Reference CRC: reflected configs use the LSB-first shift register with
    // the reversed polynomial; plain configs use the MSB-first register.
    function automatic logic [31:0] model_crc(input bq_t q, input int n);
        logic [31:0] c;
        if (rin) begin
            c = rev32(init);
            for (int i = 0; i < n; i++) begin
                c = c ^ {24'd0, q[i]};
                for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ rev32(poly)) : (c >> 1);
            end
            return c ^ rev32(xorv);
        end else begin
            c = init;
            for (int i = 0; i < n; i++) begin
                c = c ^ {q[i], 24'd0};
                for (int b = 0; b < 8; b++) c = c[31] ? ((c << 1) ^ poly) : (c << 1);
            end
            return c ^ xorv;
        end
    endfunction

    function automatic bq_t with_trailer(input bq_t p);
        logic [31:0] c;
        bq_t r;
        c = model_crc(p, p.size());
        r = p;
        r.push_back(c[31:24]); r.push_back(c[23:16]);
        r.push_back(c[15:8]);  r.push_back(c[7:0]);
        return r;
    endfunction

    task automatic drive_beat(input logic [63:0] d, input logic s, input logic e, input logic [3:0] nb);
        int w;
        in_data = d; in_sop = s; in_eop = e; in_nbytes = nb; in_valid = 1'b1;
        w = 0;
        while (in_ready !== 1'b1 && w < 20) begin
            @(posedge clk); #1; w++;
        end
        if (w >= 20) chk("beat_ready_timeout", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    endtask

    task automatic send_frame(input bq_t q, input logic zero_full);
        exp_t e;
        int   n, np, nb;
        logic [63:0] d;
        n  = q.size();
        np = (n > 4) ? n - 4 : 0;
        e.rx = '0;
        for (int i = 0; i < n; i++) e.rx = {e.rx[23:0], q[i]};
        e.crc  = model_crc(q, np);
        e.runt = (n <= 4);
        e.ok   = !e.runt && (e.crc == e.rx);
        sb.push_back(e);
        for (int s = 0; s < n; s += 8) begin
            d = '0;
            for (int j = 0; j < 8; j++) if (s + j < n) d[63-8*j -: 8] = q[s+j];
            nb = (s + 8 >= n) ? (n - s) : 0;
            if (nb == 8 && zero_full) nb = 0;
            drive_beat(d, s == 0, s + 8 >= n, 4'(nb));
        end
    endtask

    task automatic collect(input string tag, input int hold);
        exp_t e;
        int   w;
        w = 0;
        while (result_valid !== 1'b1 && w < 20) begin
            @(posedge clk); #1; w++;
        end
        chk({tag, "_latency"}, w, 0);
        e = sb.pop_front();
        chk({tag, "_ok"},   {31'd0, result_ok},   {31'd0, e.ok});
        chk({tag, "_runt"}, {31'd0, result_runt}, {31'd0, e.runt});
        chk({tag, "_crc"},  result_crc,    e.crc);
        chk({tag, "_rx"},   result_rx_crc, e.rx);
        if (e.ok) exp_ok++; else exp_bad++;
        chk({tag, "_okcnt"},  {16'd0, ok_cnt},  exp_ok);
        chk({tag, "_badcnt"}, {16'd0, bad_cnt}, exp_bad);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk({tag, "_hold_inready"}, {31'd0, in_ready},     32'd0);
            chk({tag, "_hold_valid"},   {31'd0, result_valid}, 32'd1);
            chk({tag, "_hold_crc"},     result_crc,    e.crc);
            chk({tag, "_hold_rx"},      result_rx_crc, e.rx);
        end
        result_ready = 1'b1;
        @(posedge clk); #1;
        result_ready = 1'b0;
        chk({tag, "_release_valid"},   {31'd0, result_valid}, 32'd0);
        chk({tag, "_release_inready"}, {31'd0, in_ready},     32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_inready"}, {31'd0, in_ready},     32'd1);
        chk({tag, "_valid"},   {31'd0, result_valid}, 32'd0);
        chk({tag, "_ok"},      {31'd0, result_ok},    32'd0);
        chk({tag, "_runt"},    {31'd0, result_runt},  32'd0);
        chk({tag, "_crc"},     result_crc,    32'd0);
        chk({tag, "_rx"},      result_rx_crc, 32'd0);
        chk({tag, "_okcnt"},   {16'd0, ok_cnt},    32'd0);
        chk({tag, "_badcnt"},  {16'd0, bad_cnt},   32'd0);
        chk({tag, "_abort"},   {16'd0, abort_cnt}, 32'd0);
    endtask

    task automatic cfg_crc32();
        poly = 32'h04C11DB7; init = 32'hFFFFFFFF; xorv = 32'hFFFFFFFF; rin = 1'b1; rout = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bq_t q, p;
        rst = 1'b1; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_data = '0; in_nbytes = '0;
        result_ready = 1'b0;
        cfg_crc32();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // CRC-32 check string, good trailer, EOP beat with 5 bytes
        q = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
             8'hCB, 8'hF4, 8'h39, 8'h26};
        send_frame(q, 1'b0);
        chk("t1_crc_const", result_crc, 32'hCBF43926);
        collect("t1", 0);

        // Corrupted trailer, result held for 5 cycles
        q[12] = 8'h27;
        send_frame(q, 1'b0);
        chk("t2_rx_const", result_rx_crc, 32'hCBF43927);
        collect("t2", 5);

        // CRC-32/MPEG-2
        poly = 32'h04C11DB7; init = 32'hFFFFFFFF; xorv = 32'h0; rin = 1'b0; rout = 1'b0;
        q = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
             8'h03, 8'h76, 8'hE6, 8'hE7};
        send_frame(q, 1'b0);
        chk("t3_crc_const", result_crc, 32'h0376E6E7);
        collect("t3", 0);

        // Runt: single 3-byte beat
        cfg_crc32();
        q = {8'hA1, 8'hB2, 8'hC3};
        send_frame(q, 1'b0);
        collect("t4_runt", 0);

        // Shortest legal frame: 1 payload byte + trailer
        p = {8'h41};
        send_frame(with_trailer(p), 1'b0);
        collect("t5_min", 0);

        // Random payload, full last beat encoded as nbytes=0
        p = {};
        for (int i = 0; i < 20; i++) p.push_back(8'($urandom_range(0, 255)));
        send_frame(with_trailer(p), 1'b1);
        collect("t6_rand", 0);

        // Beat without SOP in IDLE is dropped
        drive_beat(64'h1122334455667788, 1'b0, 1'b1, 4'd8);
        repeat (3) @(posedge clk);
        #1;
        chk("idle_drop_valid", {31'd0, result_valid}, 32'd0);

        // SOP in the middle of a frame aborts it and restarts
        drive_beat(64'hDEADBEEF01020304, 1'b1, 1'b0, 4'd0);
        exp_abort++;
        q = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
             8'hCB, 8'hF4, 8'h39, 8'h26};
        send_frame(q, 1'b0);
        chk("abort_cnt", {16'd0, abort_cnt}, exp_abort);
        collect("t7_after_abort", 0);

        // Reset in the middle of a frame
        drive_beat(64'h3132333435363738, 1'b1, 1'b0, 4'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_reset_outputs("midrst");
        exp_ok = 0; exp_bad = 0; exp_abort = 0;
        send_frame(q, 1'b0);
        collect("t8_post_rst", 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
